// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 128-bit block refill on miss.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache #(
    parameter int unsigned NUM_BLOCKS = 8,
    parameter int unsigned ADDR_BITS  = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          ADDRESS,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic [ADDR_BITS-5:0] MEM_ADDRESS,
    output logic                 MEM_READ,
    input  logic [127:0]         MEM_READDATA,
    input  logic                 MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          HIT_COUNT,
    output logic [15:0]          MISS_COUNT
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
    localparam int unsigned BLK_W = ADDR_BITS - 4;
    localparam int unsigned TAG_W = BLK_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t state, state_next;

    logic [TAG_W-1:0]      addr_tag;
    logic [IDX_W-1:0]      addr_idx;
    logic [1:0]            addr_off;
    logic                  unused_addr_bits;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];
    logic [BLK_W-1:0]      miss_addr;
    logic [127:0]          fill_data;

    logic                  hit;
    logic                  start_fill;
    logic                  fill_done;
    logic                  mem_read_next;
    logic [BLK_W-1:0]      mem_addr_next;

    assign addr_tag         = ADDRESS[ADDR_BITS-1:4+IDX_W];
    assign addr_idx         = ADDRESS[4 +: IDX_W];
    assign addr_off         = ADDRESS[3:2];
    assign unused_addr_bits = ^{ADDRESS[31:ADDR_BITS], ADDRESS[1:0]};

    // Lookup path is purely combinational so a hit returns in the same cycle.
    assign hit         = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
    assign INSTRUCTION = data_q[addr_idx][{addr_off, 5'b00000} +: 32];
    assign BUSYWAIT    = (state != S_IDLE) | ~hit;

    assign start_fill = (state == S_IDLE) & ~hit;
    assign fill_done  = (state == S_MEM_READ) & ~MEM_BUSYWAIT;

    // Next state plus the values MEM_READ / MEM_ADDRESS take in that state.
    always_comb begin
        state_next    = state;
        mem_read_next = 1'b0;
        mem_addr_next = '0;
        case (state)
            S_IDLE: begin
                if (!hit) begin
                    state_next    = S_MEM_READ;
                    mem_read_next = 1'b1;
                    mem_addr_next = {addr_tag, addr_idx};
                end
            end
            S_MEM_READ: begin
                if (MEM_BUSYWAIT) begin
                    mem_read_next = 1'b1;
                    mem_addr_next = miss_addr;
                end else begin
                    state_next = S_UPDATE;
                end
            end
            S_UPDATE: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            valid_q     <= '0;
            miss_addr   <= '0;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
        end else begin
            state       <= state_next;
            MEM_READ    <= mem_read_next;
            MEM_ADDRESS <= mem_addr_next;
            if (start_fill) begin
                miss_addr <= {addr_tag, addr_idx};
            end
            if (state == S_UPDATE) begin
                valid_q[miss_addr[IDX_W-1:0]] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            fill_data <= MEM_READDATA;
        end
        if (state == S_UPDATE) begin
            data_q[miss_addr[IDX_W-1:0]] <= fill_data;
            tag_q[miss_addr[IDX_W-1:0]]  <= miss_addr[BLK_W-1:IDX_W];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if ((state == S_IDLE) && hit && (HIT_COUNT != 16'hFFFF)) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (start_fill && (MISS_COUNT != 16'hFFFF)) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed test of instruction_cache against a behavioural multi-cycle instruction memory.
module tb_instruction_cache;

    logic         CLK          = 1'b0;
    logic         RESET        = 1'b0;
    logic [31:0]  ADDRESS      = '0;
    logic [127:0] MEM_READDATA = '0;
    logic         MEM_BUSYWAIT = 1'b0;
    wire  [31:0]  INSTRUCTION;
    wire          BUSYWAIT;
    wire  [5:0]   MEM_ADDRESS;
    wire          MEM_READ;
`ifdef ICACHE_STATS_EN
    wire  [15:0]  HIT_COUNT;
    wire  [15:0]  MISS_COUNT;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 5;
    int mem_cnt  = 0;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ADDRESS      (ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READ     (MEM_READ),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] wrd(input logic [5:0] a, input int w);
        return {16'hC0DE, 2'b00, a, 8'(w)};
    endfunction

    function automatic logic [127:0] blk(input logic [5:0] a);
        return {wrd(a, 3), wrd(a, 2), wrd(a, 1), wrd(a, 0)};
    endfunction

    // Memory: busy for mem_lat cycles of MEM_READ, then presents the block.
    always @(negedge CLK) begin
        if (MEM_READ) begin
            if (mem_cnt >= mem_lat) begin
                MEM_BUSYWAIT = 1'b0;
                MEM_READDATA = blk(MEM_ADDRESS);
            end else begin
                MEM_BUSYWAIT = 1'b1;
                MEM_READDATA = '0;
                mem_cnt++;
            end
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_cnt      = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Present a missing address and follow the refill until BUSYWAIT falls.
    task automatic fill(input logic [31:0] a, input logic [5:0] exp_ma,
                        input int exp_cyc, input logic [31:0] exp_word);
        int n;
        int rd;
        ADDRESS = a;
        #1;
        check("miss_busy", BUSYWAIT, 1);
        n  = 0;
        rd = 0;
        while (BUSYWAIT === 1'b1 && n < 200) begin
            if (MEM_READ === 1'b1) begin
                rd++;
                check("mem_addr", MEM_ADDRESS, exp_ma);
            end
            step();
            n++;
        end
        check("fill_cycles", n, exp_cyc);
        check("mem_read_cycles", rd, exp_cyc - 2);
        check("fill_mem_read_low", MEM_READ, 0);
        check("fill_instr", INSTRUCTION, exp_word);
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] exp_word);
        step();
        ADDRESS = a;
        #1;
        check("hit_busy", BUSYWAIT, 0);
        check("hit_mem_read", MEM_READ, 0);
        check("hit_instr", INSTRUCTION, exp_word);
    endtask

    initial begin
        repeat (2) step();
        check("rst_mem_read", MEM_READ, 0);
        check("rst_mem_addr", MEM_ADDRESS, 0);
        check("rst_busy", BUSYWAIT, 1);
`ifdef ICACHE_STATS_EN
        check("rst_hits", HIT_COUNT, 0);
        check("rst_misses", MISS_COUNT, 0);
`endif

        // Cold miss then hits across the whole line.
        RESET = 1'b1;
        fill(32'h0, 6'h00, 8, wrd(6'h00, 0));
        hit(32'h4, wrd(6'h00, 1));
        hit(32'h8, wrd(6'h00, 2));
        hit(32'hC, wrd(6'h00, 3));
`ifdef ICACHE_STATS_EN
        step();
        check("hit_count", HIT_COUNT, 4);
        check("miss_count", MISS_COUNT, 1);
`endif

        // Conflicting tag at index 0 evicts, then the original line misses again.
        fill(32'h80, 6'h08, 8, wrd(6'h08, 0));
        hit(32'h8C, wrd(6'h08, 3));
        fill(32'h0, 6'h00, 8, wrd(6'h00, 0));

        // Long memory stall keeps the request stable.
        mem_lat = 20;
        fill(32'h14, 6'h01, 23, wrd(6'h01, 1));
        mem_lat = 5;

        // Byte offset and upper PC bits are ignored.
        hit(32'h7, wrd(6'h00, 1));
        hit(32'hFFFF_FC08, wrd(6'h00, 2));
        hit(32'h18, wrd(6'h01, 2));

        // Reset in the middle of a fill drops MEM_READ before the next edge.
        step();
        ADDRESS = 32'h200;
        #1;
        check("mf_busy", BUSYWAIT, 1);
        step();
        step();
        check("mf_mem_read", MEM_READ, 1);
        check("mf_mem_addr", MEM_ADDRESS, 6'h20);
        #1;
        RESET = 1'b0;
        #1;
        check("mf_rst_mem_read", MEM_READ, 0);
        check("mf_rst_mem_addr", MEM_ADDRESS, 0);
        check("mf_rst_busy", BUSYWAIT, 1);
        step();
        RESET = 1'b1;
        fill(32'h0, 6'h00, 8, wrd(6'h00, 0));
        fill(32'h14, 6'h01, 8, wrd(6'h01, 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the CPU's PCOUT/INSTRUCTION pair and the multi-cycle instruction memory.
- On a hit it returns the 32-bit instruction in the same cycle.
- On a miss it raises BUSYWAIT to stall the CPU (the PC must hold), fetches a 128-bit block from memory, installs it, then serves the hit.

Parameters:
- NUM_BLOCKS, 8, number of cache lines (power of 2); index width IDX = log2(NUM_BLOCKS) = 3.
- ADDR_BITS, 10, low PC bits decoded; tag width = ADDR_BITS-4-IDX = 3.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RESET  input  1  asynchronous active-low reset.
- ADDRESS  input  32  PC from the CPU. Bits [ADDR_BITS-1:0] are used: tag [9:7], index [6:4], word offset [3:2]; bits [1:0] are ignored.
- INSTRUCTION  output  32  selected word of the addressed line.
- BUSYWAIT  output  1  high stalls the CPU (PC and register writes frozen).
- MEM_ADDRESS  output  ADDR_BITS-4 (6)  block address {tag,index} to instruction memory.
- MEM_READ  output  1  block read request.
- MEM_READDATA  input  128  block from memory; word w at bits [32w+31:32w].
- MEM_BUSYWAIT  input  1  memory busy; a low level while MEM_READ=1 means MEM_READDATA is valid.

Behaviour:
- Storage per line: valid bit, tag, 128-bit data. There is no dirty bit (read-only).
- Hit:
  - hit = valid[index] & (tag[index]==ADDRESS tag), combinational.
  - INSTRUCTION = data[index] word[offset], combinational from ADDRESS.
  - BUSYWAIT = (state!=IDLE) | ~hit.
- FSM states IDLE, MEM_READ, UPDATE. Reset state is IDLE.
- IDLE:
  - On hit, stay in IDLE.
  - On miss, at posedge latch {tag,index} into miss_addr and go to MEM_READ.
- MEM_READ:
  - MEM_READ=1 and MEM_ADDRESS=miss_addr, both registered-stable for the whole state.
  - While MEM_BUSYWAIT=1, stay.
  - At the first posedge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
- UPDATE:
  - At posedge write data[miss_idx], tag[miss_idx]=miss_tag, valid[miss_idx]=1, then go to IDLE.
  - MEM_READ=0.
- Outside MEM_READ: MEM_READ=0 and MEM_ADDRESS=0.
- Miss penalty: 1 (detect) + memory latency + 1 (UPDATE) cycles. The following cycle is a hit and BUSYWAIT falls.
- Refill always targets miss_addr. If ADDRESS changes during a fill (protocol violation), the fill still completes to miss_addr. Back in IDLE, the new ADDRESS is evaluated normally.
- A conflicting tag at the same index overwrites the line unconditionally; there is no writeback.
- RESET low at any time, including mid-fill:
  - immediately all valid=0, state=IDLE, MEM_READ=0, MEM_ADDRESS=0, miss_addr=0.
  - Data/tag arrays need not clear.
- After reset, the first access always misses, so BUSYWAIT=1 while RESET is deasserted and ADDRESS is presented.
- INSTRUCTION reset value is the don't-care data of line 0; the CPU must not consume it while BUSYWAIT=1.
- MEM_BUSYWAIT glitches while MEM_READ=0 are ignored.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds output ports HIT_COUNT [15:0] and MISS_COUNT [15:0].
  - HIT_COUNT increments on each posedge in IDLE with hit=1.
  - MISS_COUNT increments on each IDLE->MEM_READ transition.
  - Both saturate at 16'hFFFF and clear on RESET.
- Undefined: the ports and counters are absent and there is no logic overhead. All other behaviour is identical.

Test Plan:
- Cold miss: release RESET, ADDRESS=0x0. BUSYWAIT=1; MEM_READ=1 with MEM_ADDRESS=6'h00. Memory answers after 5 cycles with block {W3,W2,W1,W0}. UPDATE follows, then BUSYWAIT=0 and INSTRUCTION=W0.
- Hit sequence: after the above, ADDRESS=0x4, 0x8, 0xC. BUSYWAIT stays 0; INSTRUCTION=W1, W2, W3 on consecutive cycles; MEM_READ never asserts.
- Conflict eviction: ADDRESS=0x80 (tag 1, index 0). MEM_ADDRESS=6'h08 and the line is refilled. ADDRESS=0x0 then misses again with MEM_ADDRESS=6'h00.
- Memory stall: MEM_BUSYWAIT held high for 20 cycles. MEM_READ and MEM_ADDRESS stay stable all 20 cycles; no UPDATE occurs until MEM_BUSYWAIT=0.
- Reset mid-fill: assert RESET low during MEM_READ. MEM_READ drops without waiting for CLK. After release, ADDRESS=0x0 misses again (valid was cleared).
- With ICACHE_STATS_EN: run the first two scenarios. Expect MISS_COUNT=1 and HIT_COUNT=4 (0x0 post-fill, 0x4, 0x8, 0xC).
